vault_code_tx: RTL and testbench
================================

VAULT_CODE_TX -- requirements
Module: vault_code_tx

Interface
REQ-001 SHALL have parameter CODE_W, default 4: number of code bits per frame, legal range 2..16.
REQ-002 SHALL have parameter BIT_DIV, default 1: clock cycles each bit is held on code_out, legal range 1..255.
REQ-003 SHALL have parameter GAP_CYC, default 2: idle-low cycles after the last bit before tx_done, legal range 0..255.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: request to transmit code_word; accepted only in IDLE.
REQ-007 SHALL have port code_word, input, CODE_W bits: code to send, MSB first.
REQ-008 SHALL have port code_out, output, 1 bit: registered serial code line; idle level 0.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until DONE is left.
REQ-010 SHALL have port tx_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-011 SHALL implement states IDLE, SEND, GAP and DONE, with the state register updated on clk and cleared by reset.
REQ-012 IDLE: code_out=0, busy=0; start=1 at edge k captures code_word into a shift register, loads bit index CODE_W-1, and moves to SEND.
REQ-013 SEND: code_out SHALL equal shadow[bit index], registered, first valid in cycle k+1.
REQ-014 SEND: each bit SHALL be held exactly BIT_DIV cycles, timed by a tick counter that reloads at BIT_DIV-1 and decrements to 0.
REQ-015 SEND: on the final tick of bit 0, the next state SHALL be GAP if GAP_CYC>0, otherwise DONE.
REQ-016 GAP: code_out=0 for exactly GAP_CYC cycles, then move to DONE.
REQ-017 DONE: tx_done=1 for exactly one cycle, code_out=0, then unconditional return to IDLE.
REQ-018 A start asserted in DONE SHALL be ignored; the earliest accepted restart is the first IDLE cycle.
REQ-019 A start asserted while busy=1 SHALL be ignored with no queuing, and the frame in flight continues unchanged.
REQ-020 code_word changes after capture SHALL NOT affect the frame in flight.
REQ-021 Frame length SHALL be exactly CODE_W*BIT_DIV + GAP_CYC + 1 cycles, from first bit to tx_done inclusive.
REQ-022 The bit index SHALL be clog2(CODE_W) bits wide and never wrap below 0; the tick counter SHALL be 8 bits wide.
REQ-023 An unreachable state encoding SHALL recover to IDLE on the next edge with code_out=0.

Reset
REQ-024 Reset SHALL force state=IDLE, code_out=0, busy=0, tx_done=0, and clear the shift register, bit index and tick counter.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with no tx_done pulse.
REQ-026 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-027 Shared package vault_pkg SHALL hold the state enumeration, the default CODE_W/BIT_DIV/GAP_CYC constants, and the default vault code 4'b1011.
REQ-028 One sub-module, vault_bit_tick, SHALL implement the BIT_DIV down-counter with load and tick outputs; all other logic is in vault_code_tx.

Verification
REQ-029 Defaults, code_word=4'b1011, start pulse at cycle 0 -> code_out 1,0,1,1 in cycles 1-4, 0 in cycles 5-6, tx_done=1 only in cycle 7, busy=1 in cycles 1-7.
REQ-030 BIT_DIV=3, code_word=4'b0110 -> code_out 0,0,0,1,1,1,1,1,1,0,0,0 over cycles 1-12, and tx_done in cycle 15.
REQ-031 start held high continuously with code_word=4'b1001 -> frames back-to-back with one IDLE cycle between tx_done and the next first bit; code_word toggled mid-frame does not alter the bits.
REQ-032 Reset asserted in cycle 3 of a 4'b1011 frame -> code_out=0 and busy=0 immediately, no tx_done, and a new start after release sends the full frame.
REQ-033 GAP_CYC=0, CODE_W=8, code_word=8'hA5 -> bits 1,0,1,0,0,1,0,1 in cycles 1-8 and tx_done in cycle 9.

Source files
------------

// File: rtl/vault_pkg.sv
// Shared types and default constants for the vault code transmitter.
package vault_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } vault_state_e;

  localparam int DEF_CODE_W  = 4;
  localparam int DEF_BIT_DIV = 1;
  localparam int DEF_GAP_CYC = 2;

  localparam logic [DEF_CODE_W-1:0] DEF_VAULT_CODE = 4'b1011;

endpackage

// File: rtl/vault_bit_tick.sv
// Bit-period down-counter: reloads to BIT_DIV-1 on load, ticks when it reaches 0.
module vault_bit_tick #(
  parameter int BIT_DIV = vault_pkg::DEF_BIT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(BIT_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == 8'd0);

endmodule

// File: rtl/vault_code_tx.sv
// Serial vault-code transmitter: sends a captured code word MSB first,
// then an idle gap, then a one-cycle tx_done pulse.
module vault_code_tx
  import vault_pkg::*;
#(
  parameter int CODE_W  = DEF_CODE_W,
  parameter int BIT_DIV = DEF_BIT_DIV,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CODE_W-1:0] code_word,
  output logic              code_out,
  output logic              busy,
  output logic              tx_done
);

  localparam int         IDX_W    = $clog2(CODE_W);
  localparam logic [7:0] GAP_LOAD = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  vault_state_e      state_q, state_d;
  logic [CODE_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_dec;
  logic [7:0]        gap_q, gap_d;
  logic              code_out_q, code_out_d;
  logic              tick_load, tick;

  vault_bit_tick #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_tick (
    .clk   (clk),
    .reset (reset),
    .load  (tick_load),
    .tick  (tick)
  );

  assign idx_dec = idx_q - IDX_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    code_out_d = 1'b0;
    tick_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d   = code_word;
          idx_d      = IDX_W'(CODE_W - 1);
          code_out_d = code_word[CODE_W-1];
          tick_load  = 1'b1;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        code_out_d = shadow_q[idx_q];
        if (tick) begin
          if (idx_q == '0) begin
            // Last bit done: line drops to idle level on the same edge.
            code_out_d = 1'b0;
            if (GAP_CYC > 0) begin
              gap_d   = GAP_LOAD;
              state_d = ST_GAP;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            idx_d      = idx_dec;
            code_out_d = shadow_q[idx_dec];
            tick_load  = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = ST_DONE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      gap_q      <= 8'd0;
      code_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      code_out_q <= code_out_d;
    end
  end

  assign code_out = code_out_q;
  assign busy     = (state_q != ST_IDLE);
  assign tx_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_vault_code_tx.sv
// Directed bench for vault_code_tx: three parameterisations sharing one clock.
module tb_vault_code_tx;
  import vault_pkg::*;

  logic clk;
  logic reset;

  logic       a_start, a_out, a_busy, a_done;
  logic [3:0] a_code;
  logic       b_start, b_out, b_busy, b_done;
  logic [3:0] b_code;
  logic       c_start, c_out, c_busy, c_done;
  logic [7:0] c_code;

  int n_checks = 0;
  int n_pass   = 0;

  vault_code_tx #(.CODE_W(4), .BIT_DIV(1), .GAP_CYC(2)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .code_word(a_code),
    .code_out(a_out), .busy(a_busy), .tx_done(a_done)
  );

  vault_code_tx #(.CODE_W(4), .BIT_DIV(3), .GAP_CYC(2)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .code_word(b_code),
    .code_out(b_out), .busy(b_busy), .tx_done(b_done)
  );

  vault_code_tx #(.CODE_W(8), .BIT_DIV(1), .GAP_CYC(0)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .code_word(c_code),
    .code_out(c_out), .busy(c_busy), .tx_done(c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Default-config 4'b1011 frame, cycles 1..8 after the accepting edge.
  // With poke set, a start with a different code is raised in cycle 3.
  task automatic frame_a(input string tag, input bit poke);
    int co[8];
    int dn[8];
    int by[8];
    co = '{1, 0, 1, 1, 0, 0, 0, 0};
    dn = '{0, 0, 0, 0, 0, 0, 1, 0};
    by = '{1, 1, 1, 1, 1, 1, 1, 0};
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("%s c%0d code_out", tag, c), int'(a_out),  co[c-1]);
      check($sformatf("%s c%0d tx_done",  tag, c), int'(a_done), dn[c-1]);
      check($sformatf("%s c%0d busy",     tag, c), int'(a_busy), by[c-1]);
      if (poke && c == 3) begin
        a_start = 1'b1;
        a_code  = 4'b0000;
      end else begin
        a_start = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_co[16];
    int b_dn[16];
    int b_by[16];
    int h_co[16];
    int h_dn[16];
    int h_by[16];
    int c_co[10];
    int c_dn[10];

    reset   = 1'b1;
    a_start = 1'b0; a_code = 4'b0000;
    b_start = 1'b0; b_code = 4'b0000;
    c_start = 1'b0; c_code = 8'h00;

    // Reset state
    step();
    step();
    check("rst a code_out", int'(a_out),  0);
    check("rst a busy",     int'(a_busy), 0);
    check("rst a tx_done",  int'(a_done), 0);
    check("rst c code_out", int'(c_out),  0);
    check("rst c busy",     int'(c_busy), 0);

    // Default frame, start on the first edge after reset release; a start
    // raised mid-frame must be ignored and not queued.
    reset   = 1'b0;
    a_code  = DEF_VAULT_CODE;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    frame_a("dflt", 1'b1);
    check("dflt no requeue busy", int'(a_busy), 0);

    // BIT_DIV=3, code 0110
    b_co = '{0,0,0,1,1,1,1,1,1,0,0,0,0,0,0,0};
    b_dn = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};
    b_by = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    b_code  = 4'b0110;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_code  = 4'b1111;
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("div3 c%0d code_out", c), int'(b_out),  b_co[c-1]);
      check($sformatf("div3 c%0d tx_done",  c), int'(b_done), b_dn[c-1]);
      check($sformatf("div3 c%0d busy",     c), int'(b_busy), b_by[c-1]);
      step();
    end

    // start held high: back-to-back 1001 frames, code_word toggled mid-frame
    h_co = '{1,0,0,1,0,0,0,0, 1,0,0,1,0,0,0,0};
    h_dn = '{0,0,0,0,0,0,1,0, 0,0,0,0,0,0,1,0};
    h_by = '{1,1,1,1,1,1,1,0, 1,1,1,1,1,1,1,0};
    a_code  = 4'b1001;
    a_start = 1'b1;
    step();
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("held c%0d code_out", c), int'(a_out),  h_co[c-1]);
      check($sformatf("held c%0d tx_done",  c), int'(a_done), h_dn[c-1]);
      check($sformatf("held c%0d busy",     c), int'(a_busy), h_by[c-1]);
      if (c == 2 || c == 10) a_code = 4'b0110;
      if (c == 5 || c == 13) a_code = 4'b1001;
      if (c == 16) a_start = 1'b0;
      step();
    end

    // Reset in cycle 3 of a 1011 frame aborts at once, then a clean restart
    a_code  = 4'b1011;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("abort c1 code_out", int'(a_out), 1);
    step();
    check("abort c2 code_out", int'(a_out), 0);
    step();
    reset = 1'b1;
    #1;
    check("abort code_out", int'(a_out),  0);
    check("abort busy",     int'(a_busy), 0);
    check("abort tx_done",  int'(a_done), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("abort hold%0d tx_done", c), int'(a_done), 0);
      check($sformatf("abort hold%0d busy", c),    int'(a_busy), 0);
    end
    reset   = 1'b0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    frame_a("restart", 1'b0);

    // CODE_W=8, GAP_CYC=0, code A5
    c_co = '{1,0,1,0,0,1,0,1,0,0};
    c_dn = '{0,0,0,0,0,0,0,0,1,0};
    c_code  = 8'hA5;
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    c_code  = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("w8 c%0d code_out", c), int'(c_out),  c_co[c-1]);
      check($sformatf("w8 c%0d tx_done",  c), int'(c_done), c_dn[c-1]);
      check($sformatf("w8 c%0d busy",     c), int'(c_busy), (c <= 9) ? 1 : 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
